// File: rtl/uart_link_ctrl_if.sv
// Link bundle between uart_link_ctrl and its surroundings: the UART RX/TX
// FIFO handshakes, the decoded key outputs and the game-logic message stream.
//   rx_byte/rx_fifo_empty/rx_fifo_pop : RX FIFO head, empty flag, pop strobe
//   tx_fifo_full/tx_byte/transmit     : TX FIFO full flag, write data, write strobe
//   keys/key_strobe                   : held key flags, decode pulse
//   msg_valid/msg_byte/msg_ready      : outbound message handshake
// master = controller side, slave = FIFO/game-logic side.
interface uart_link_ctrl_if;
  logic [7:0] rx_byte;
  logic       rx_fifo_empty;
  logic       rx_fifo_pop;
  logic       tx_fifo_full;
  logic [7:0] tx_byte;
  logic       transmit;
  logic [7:0] keys;
  logic       key_strobe;
  logic       msg_valid;
  logic [7:0] msg_byte;
  logic       msg_ready;

  modport master (
    input  rx_byte, rx_fifo_empty, tx_fifo_full, msg_valid, msg_byte,
    output rx_fifo_pop, tx_byte, transmit, keys, key_strobe, msg_ready
  );

  modport slave (
    output rx_byte, rx_fifo_empty, tx_fifo_full, msg_valid, msg_byte,
    input  rx_fifo_pop, tx_byte, transmit, keys, key_strobe, msg_ready
  );
endinterface

// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: drains the UART RX FIFO one byte per two cycles, decodes
// key bytes into held key flags with per-key auto-release timers, echoes
// recognised keys and arbitrates the TX FIFO round-robin between key echoes
// and the game-logic message stream.
// Ports:
//   CLK   clock
//   RESET synchronous, active-high reset
//   link  uart_link_ctrl_if.master (RX FIFO, TX FIFO, keys, message handshake)
// Parameter HOLD_CYCLES: cycles a key flag stays high after its last press.
module uart_link_ctrl #(
  parameter int unsigned HOLD_CYCLES = 5000000
) (
  input  logic             CLK,
  input  logic             RESET,
  uart_link_ctrl_if.master link
);
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {RX_IDLE, RX_POP} rx_state_t;

  rx_state_t     rx_state, rx_state_nx;
  logic          rx_start;
  logic          dec_hit;
  logic [2:0]    dec_idx;
  logic [7:0]    dec_echo;
  logic [CW-1:0] hold_cnt [8];
  logic [7:0]    keys_w;
  logic          key_strobe_q;
  logic          echo_pending;
  logic [7:0]    echo_buf;
  logic          last_echo;
  logic          transmit_q;
  logic [7:0]    tx_byte_q;
  logic          can_tx, grant_echo, grant_msg;

  // RX sequencer: IDLE samples and decodes the head byte, POP is the cycle
  // the pop strobe is visible and gives the FIFO flags a cycle to settle.
  always_ff @(posedge CLK) begin
    if (RESET) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_start    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        // An undelivered echo stalls RX so the single echo buffer is never overrun.
        if (!link.rx_fifo_empty && !echo_pending) begin
          rx_start    = 1'b1;
          rx_state_nx = RX_POP;
        end
      end
      RX_POP:  rx_state_nx = RX_IDLE;
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    dec_hit  = 1'b1;
    dec_idx  = '0;
    dec_echo = '0;
    case (link.rx_byte)
      8'h77: begin dec_idx = 3'd7; dec_echo = 8'h57; end
      8'h73: begin dec_idx = 3'd6; dec_echo = 8'h53; end
      8'h61: begin dec_idx = 3'd5; dec_echo = 8'h41; end
      8'h64: begin dec_idx = 3'd4; dec_echo = 8'h44; end
      8'h6A: begin dec_idx = 3'd3; dec_echo = 8'h4A; end
      8'h6B: begin dec_idx = 3'd2; dec_echo = 8'h4B; end
      8'h6C: begin dec_idx = 3'd1; dec_echo = 8'h4C; end
      8'h20: begin dec_idx = 3'd0; dec_echo = 8'h5A; end
      default: dec_hit = 1'b0;
    endcase
  end

  // Key flags are derived from their counters: a flag is high exactly while
  // its counter is nonzero, so the 1->0 transition clears it and a reload
  // in the same cycle keeps it set.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < 8; i++) begin
      if (RESET)
        hold_cnt[i] <= '0;
      else if (rx_start && !dec_hit)
        hold_cnt[i] <= '0;
      else if (rx_start && (dec_idx == 3'(i)))
        hold_cnt[i] <= CW'(HOLD_CYCLES);
      else if (hold_cnt[i] != '0)
        hold_cnt[i] <= hold_cnt[i] - CW'(1);
    end
  end

  always_comb begin
    keys_w = '0;
    for (int unsigned i = 0; i < 8; i++)
      keys_w[i] = (hold_cnt[i] != '0);
  end

  // TX arbiter: free when the FIFO has room and no write is in flight.
  // last_echo=1 means the echo source won last, so msg wins a tie next.
  always_comb begin
    can_tx     = !link.tx_fifo_full && !transmit_q;
    grant_echo = can_tx && echo_pending && (!link.msg_valid || !last_echo);
    grant_msg  = can_tx && link.msg_valid && (!echo_pending || last_echo);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      echo_pending <= 1'b0;
      echo_buf     <= '0;
      last_echo    <= 1'b0;
      transmit_q   <= 1'b0;
      tx_byte_q    <= '0;
      key_strobe_q <= 1'b0;
    end else begin
      transmit_q   <= grant_echo || grant_msg;
      key_strobe_q <= rx_start && dec_hit;
      if (grant_echo)     tx_byte_q <= echo_buf;
      else if (grant_msg) tx_byte_q <= link.msg_byte;
      if (grant_echo || grant_msg) last_echo <= grant_echo;
      // A new echo is only loaded while none is pending, so it never
      // collides with an echo grant.
      if (rx_start && dec_hit) begin
        echo_pending <= 1'b1;
        echo_buf     <= dec_echo;
      end else if (grant_echo) begin
        echo_pending <= 1'b0;
      end
    end
  end

  assign link.rx_fifo_pop = (rx_state == RX_POP);
  assign link.keys        = keys_w;
  assign link.key_strobe  = key_strobe_q;
  assign link.transmit    = transmit_q;
  assign link.tx_byte     = tx_byte_q;
  assign link.msg_ready   = grant_msg && !RESET;
endmodule

// File: tb/tb_uart_link_ctrl.sv
// Testbench for uart_link_ctrl: an RX FIFO and message source around the DUT,
// a behavioural model (echo queue, per-key expiry times, round-robin owner)
// compared against the DUT every cycle, and directed scenarios with literal
// expectations followed by a randomized phase.
module tb_uart_link_ctrl;
  localparam int unsigned HOLD = 10;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  uart_link_ctrl_if link ();

  uart_link_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .link  (link)
  );

  always #5 CLK = ~CLK;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  // index = keys bit
  logic [7:0] key_chr  [8] = '{8'h20, 8'h6C, 8'h6B, 8'h6A, 8'h64, 8'h61, 8'h73, 8'h77};
  logic [7:0] echo_chr [8] = '{8'h5A, 8'h4C, 8'h4B, 8'h4A, 8'h44, 8'h41, 8'h53, 8'h57};

  // environment
  logic [7:0] rxq [$];
  bit         msg_auto = 1'b0;
  logic [7:0] msg_next = 8'h41;
  logic [7:0] tx_log [$];
  int         tx_cyc [$];

  // model
  bit         m_valid      = 1'b0;
  int         m_last_start = -10;
  logic [7:0] m_echo [$];
  int         m_expire [8];
  bit         m_last_echo  = 1'b0;
  logic       e_pop = 1'b0, e_strobe = 1'b0, e_transmit = 1'b0;
  logic [7:0] e_tx_byte = 8'h00, e_keys = 8'h00;
  logic       exp_mr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at this edge.
  task automatic model_step();
    bit can, ge, gm, start;
    int hit;
    if (RESET) begin
      m_valid      = 1'b1;
      m_echo.delete();
      for (int i = 0; i < 8; i++) m_expire[i] = 0;
      m_last_echo  = 1'b0;
      m_last_start = -10;
      e_pop = 1'b0; e_strobe = 1'b0; e_transmit = 1'b0;
      e_tx_byte = 8'h00; e_keys = 8'h00;
    end else begin
      can = !link.tx_fifo_full && !e_transmit;
      ge = 1'b0; gm = 1'b0;
      if (can) begin
        if (m_echo.size() != 0 && link.msg_valid) begin
          if (m_last_echo) gm = 1'b1; else ge = 1'b1;
        end else if (m_echo.size() != 0) ge = 1'b1;
        else if (link.msg_valid) gm = 1'b1;
      end
      start = (cyc != m_last_start + 1) && !link.rx_fifo_empty && (m_echo.size() == 0);
      hit = -1;
      if (start)
        for (int i = 0; i < 8; i++) if (link.rx_byte == key_chr[i]) hit = i;
      e_transmit = ge || gm;
      if (ge) e_tx_byte = m_echo.pop_front();
      else if (gm) e_tx_byte = link.msg_byte;
      if (ge || gm) m_last_echo = ge;
      e_pop    = start;
      e_strobe = start && (hit >= 0);
      if (start) begin
        m_last_start = cyc;
        if (hit >= 0) begin
          m_expire[hit] = cyc + 1 + int'(HOLD);
          m_echo.push_back(echo_chr[hit]);
        end else begin
          for (int i = 0; i < 8; i++) m_expire[i] = 0;
        end
      end
      for (int i = 0; i < 8; i++) e_keys[i] = (cyc + 1 < m_expire[i]);
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Per-cycle comparison, mid-cycle.
  initial forever begin
    @(negedge CLK);
    if (link.transmit === 1'b1) begin
      tx_log.push_back(link.tx_byte);
      tx_cyc.push_back(cyc);
    end
    if (m_valid) begin
      exp_mr = !RESET && link.msg_valid && !link.tx_fifo_full && !e_transmit &&
               ((m_echo.size() == 0) || m_last_echo);
      check("rx_fifo_pop", 32'(link.rx_fifo_pop), 32'(e_pop));
      check("key_strobe",  32'(link.key_strobe),  32'(e_strobe));
      check("keys",        32'(link.keys),        32'(e_keys));
      check("transmit",    32'(link.transmit),    32'(e_transmit));
      check("tx_byte",     32'(link.tx_byte),     32'(e_tx_byte));
      check("msg_ready",   32'(link.msg_ready),   32'(exp_mr));
    end
  end

  task automatic apply_rx();
    link.rx_fifo_empty = (rxq.size() == 0);
    link.rx_byte       = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rxq.push_back(b);
    apply_rx();
  endtask

  // One clock: observe handshakes mid-cycle, react just after the edge.
  task automatic cycle();
    logic pop_seen, acc_seen;
    @(negedge CLK);
    pop_seen = link.rx_fifo_pop;
    acc_seen = link.msg_valid & link.msg_ready;
    @(posedge CLK);
    #1;
    if (pop_seen === 1'b1 && rxq.size() != 0) void'(rxq.pop_front());
    if (acc_seen === 1'b1) begin
      if (msg_auto) link.msg_byte = msg_next;
      else          link.msg_valid = 1'b0;
    end
    apply_rx();
  endtask

  task automatic drain();
    int n = 0;
    link.tx_fifo_full = 1'b0;
    while (rxq.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    check("drain_rx", 32'(rxq.size()), 32'd0);
    repeat (8) cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hi, n, pops, txs;
    logic [7:0] b;

    link.rx_byte = 8'h00; link.rx_fifo_empty = 1'b1; link.tx_fifo_full = 1'b0;
    link.msg_valid = 1'b1; link.msg_byte = 8'h41;

    // Reset values, msg_ready held low under RESET.
    repeat (3) cycle();
    check("rst_tx_byte",  32'(link.tx_byte),     32'h00);
    check("rst_transmit", 32'(link.transmit),    32'h0);
    check("rst_pop",      32'(link.rx_fifo_pop), 32'h0);
    check("rst_keys",     32'(link.keys),        32'h00);
    check("rst_strobe",   32'(link.key_strobe),  32'h0);
    check("rst_msg_ready",32'(link.msg_ready),   32'h0);
    link.msg_valid = 1'b0;
    RESET = 1'b0;
    repeat (2) cycle();

    // 'w': pop/keys/strobe at N+1, echo 0x57 at N+2.
    rx_push(8'h77);
    cycle();
    check("w_pop",    32'(link.rx_fifo_pop), 32'h1);
    check("w_keys",   32'(link.keys),        32'h80);
    check("w_strobe", 32'(link.key_strobe),  32'h1);
    check("w_notx",   32'(link.transmit),    32'h0);
    cycle();
    check("w_tx",     32'(link.transmit),    32'h1);
    check("w_txbyte", 32'(link.tx_byte),     32'h57);
    repeat (12) cycle();

    // Hold time of a single 'd', then a reload late in the hold.
    rx_push(8'h64);
    cycle();
    hi = 0;
    while (link.keys[4] === 1'b1 && hi < 40) begin hi++; cycle(); end
    check("d_hold_len", 32'(hi), 32'd10);
    check("d_released", 32'(link.keys), 32'h00);
    rx_push(8'h64);
    cycle();
    repeat (7) cycle();
    rx_push(8'h64);
    cycle();
    check("d_reload_strobe", 32'(link.key_strobe), 32'h1);
    hi = 0;
    while (link.keys[4] === 1'b1 && hi < 40) begin hi++; cycle(); end
    check("d_reload_len", 32'(hi), 32'd10);
    drain();

    // 'w' then 'x': keys cleared on 'x', no strobe, no echo.
    tx_log.delete(); tx_cyc.delete();
    rx_push(8'h77); rx_push(8'h78);
    cycle();
    check("wx_keys_w", 32'(link.keys), 32'h80);
    n = 0;
    do begin cycle(); n++; end while (link.rx_fifo_pop !== 1'b1 && n < 10);
    check("wx_gap",    32'(n),                  32'd2);
    check("wx_keys_x", 32'(link.keys),          32'h00);
    check("wx_strobe", 32'(link.key_strobe),    32'h0);
    repeat (4) cycle();
    check("wx_ntx",    32'(tx_log.size()),      32'd1);
    if (tx_log.size() != 0) check("wx_echo", 32'(tx_log[0]), 32'h57);
    drain();

    // Round-robin between echoes and messages from a reset pointer.
    RESET = 1'b1; cycle(); RESET = 1'b0;
    link.tx_fifo_full = 1'b1;
    rx_push(8'h77); rx_push(8'h77); rx_push(8'h77);
    repeat (6) cycle();
    tx_log.delete(); tx_cyc.delete();
    msg_next = 8'h41; link.msg_byte = 8'h41; link.msg_valid = 1'b1; msg_auto = 1'b1;
    link.tx_fifo_full = 1'b0;
    repeat (12) cycle();
    msg_auto = 1'b0;
    n = 0;
    while (link.msg_valid === 1'b1 && n < 20) begin cycle(); n++; end
    check("rr_msg_done", 32'(link.msg_valid), 32'h0);
    check("rr_count_ge3", 32'(tx_log.size() >= 3), 32'h1);
    if (tx_log.size() >= 3) begin
      check("rr_first",  32'(tx_log[0]), 32'h57);
      check("rr_second", 32'(tx_log[1]), 32'h41);
      check("rr_third",  32'(tx_log[2]), 32'h57);
      check("rr_gap1", 32'(tx_cyc[1] - tx_cyc[0] >= 2), 32'h1);
      check("rr_gap2", 32'(tx_cyc[2] - tx_cyc[1] >= 2), 32'h1);
    end
    drain();

    // TX full for 20 cycles with three bytes waiting.
    link.tx_fifo_full = 1'b1;
    tx_log.delete(); tx_cyc.delete();
    rx_push(8'h77); rx_push(8'h73); rx_push(8'h61);
    pops = 0; txs = 0;
    repeat (20) begin
      cycle();
      if (link.rx_fifo_pop === 1'b1) pops++;
      if (link.transmit === 1'b1) txs++;
    end
    check("full_pops", 32'(pops), 32'd1);
    check("full_txs",  32'(txs),  32'd0);
    link.tx_fifo_full = 1'b0;
    n = 0;
    while (tx_log.size() < 3 && n < 40) begin cycle(); n++; end
    check("full_drain_n", 32'(tx_log.size()), 32'd3);
    if (tx_log.size() >= 3) begin
      check("full_e0", 32'(tx_log[0]), 32'h57);
      check("full_e1", 32'(tx_log[1]), 32'h53);
      check("full_e2", 32'(tx_log[2]), 32'h41);
    end
    drain();

    // RESET right after the pop of 'j' drops the echo.
    tx_log.delete(); tx_cyc.delete();
    rx_push(8'h6A);
    cycle();
    check("j_pop",  32'(link.rx_fifo_pop), 32'h1);
    check("j_keys", 32'(link.keys),        32'h08);
    RESET = 1'b1;
    cycle();
    check("j_rst_keys", 32'(link.keys),     32'h00);
    check("j_rst_tx",   32'(link.transmit), 32'h0);
    RESET = 1'b0;
    repeat (10) cycle();
    check("j_no_echo", 32'(tx_log.size()), 32'd0);

    // Randomized traffic; the per-cycle model comparison does the checking.
    for (int k = 0; k < 3000; k++) begin
      if (RESET) RESET = 1'b0;
      else if ($urandom_range(0, 199) == 0) RESET = 1'b1;
      link.tx_fifo_full = ($urandom_range(0, 9) < 3);
      if (rxq.size() < 4 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) < 6) b = key_chr[$urandom_range(0, 7)];
        else b = 8'($urandom);
        rx_push(b);
      end
      if (link.msg_valid !== 1'b1 && $urandom_range(0, 3) == 0) begin
        link.msg_byte  = 8'($urandom);
        link.msg_valid = 1'b1;
      end
      cycle();
    end
    RESET = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
